// File: rtl/single_cycle_run_ctrl.sv
// Run controller for a set of cores: holds core resets, releases them (optionally staggered),
// then supervises halts, a cycle budget and abort, latching per-core pass/fail status.
module single_cycle_run_ctrl #(
  parameter int NUM_CORES  = 1,
  parameter int RST_HOLD   = 2,
  parameter int STAGGER    = 0,
  parameter int MAX_CYCLES = 5,
  parameter int CNT_W      = 32,
  parameter int AUTO_START = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start_i,
  input  logic                 abort_i,
  input  logic [NUM_CORES-1:0] halt_i,
  input  logic [NUM_CORES-1:0] pass_i,
  output logic [NUM_CORES-1:0] core_rst_n,
  output logic                 busy,
  output logic                 done,
  output logic                 timeout,
  output logic                 aborted,
  output logic [NUM_CORES-1:0] halted,
  output logic [NUM_CORES-1:0] pass,
  output logic [NUM_CORES-1:0] fail,
  output logic [CNT_W-1:0]     cycle_count,
  output logic [1:0]           state_dbg
);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_HOLD = 2'd1, S_RUN = 2'd2, S_DONE = 2'd3} state_t;

  localparam logic [31:0]      LAST_REL = 32'(RST_HOLD - 1 + (NUM_CORES - 1) * STAGGER);
  localparam logic [CNT_W-1:0] LAST_CYC = CNT_W'(MAX_CYCLES - 1);

  function automatic logic [31:0] rel_point(input int idx);
    return 32'(RST_HOLD - 1 + idx * STAGGER);
  endfunction

  state_t                 state, state_nxt;
  logic [1:0]             rst_sync;
  logic                   srst_n;
  logic [31:0]            hold_cnt;
  logic [NUM_CORES-1:0]   halt_take, halted_nxt, unhalted_fail;
  logic                   all_halt, abort_hit, timeout_hit, enter_hold, enter_done;

  // Assertion reaches every flop at once; release is seen only after two clock edges.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rst_sync <= 2'b00;
    else      rst_sync <= {rst_sync[0], 1'b1};
  end
  assign srst_n = rst_sync[1];

  assign halt_take     = halt_i & core_rst_n & ~halted;
  assign halted_nxt    = halted | halt_take;
  assign all_halt      = &halted_nxt;
  assign abort_hit     = abort_i && (state == S_HOLD || state == S_RUN);
  assign timeout_hit   = (state == S_RUN) && !abort_hit && !all_halt && (cycle_count == LAST_CYC);
  assign unhalted_fail = (abort_hit || timeout_hit) ? ~halted_nxt : '0;
  assign enter_hold    = (state == S_IDLE || state == S_DONE) && (state_nxt == S_HOLD);
  assign enter_done    = (state != S_DONE) && (state_nxt == S_DONE);

  always_ff @(posedge clk or negedge srst_n) begin
    if (!srst_n) state <= S_IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (start_i || AUTO_START != 0) state_nxt = S_HOLD;
      S_HOLD: begin
        if (abort_hit)                state_nxt = S_DONE;
        else if (hold_cnt == LAST_REL) state_nxt = S_RUN;
      end
      S_RUN:  if (abort_hit || all_halt || cycle_count == LAST_CYC) state_nxt = S_DONE;
      S_DONE: if (start_i) state_nxt = S_HOLD;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy      = (state == S_HOLD) || (state == S_RUN);
    done      = (state == S_DONE);
    state_dbg = state;
  end

  always_ff @(posedge clk or negedge srst_n) begin
    if (!srst_n) begin
      hold_cnt    <= '0;
      cycle_count <= '0;
      halted      <= '0;
      pass        <= '0;
      fail        <= '0;
      timeout     <= 1'b0;
      aborted     <= 1'b0;
    end else if (enter_hold) begin
      hold_cnt    <= '0;
      cycle_count <= '0;
      halted      <= '0;
      pass        <= '0;
      fail        <= '0;
      timeout     <= 1'b0;
      aborted     <= 1'b0;
    end else begin
      if (state == S_HOLD) hold_cnt <= hold_cnt + 32'd1;
      if (state == S_RUN && cycle_count != '1) cycle_count <= cycle_count + 1'b1;
      halted <= halted_nxt;
      pass   <= pass | (halt_take & pass_i);
      fail   <= fail | (halt_take & ~pass_i) | unhalted_fail;
      if (timeout_hit) timeout <= 1'b1;
      if (abort_hit)   aborted <= 1'b1;
    end
  end

  // Release points are compared against the pre-increment hold count of the current cycle.
  always_ff @(posedge clk or negedge srst_n) begin
    if (!srst_n) begin
      core_rst_n <= '0;
    end else if (enter_done) begin
      core_rst_n <= '0;
    end else if (state == S_HOLD) begin
      for (int i = 0; i < NUM_CORES; i++)
        if (hold_cnt == rel_point(i)) core_rst_n[i] <= 1'b1;
    end
  end

endmodule

// File: tb/tb_single_cycle_run_ctrl.sv
// Directed bench for single_cycle_run_ctrl: default single-core instance plus a
// three-core staggered instance; run results go through an expected queue.
module tb_single_cycle_run_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  logic [18:0] exp_q[$];

  // default instance
  logic        a_rst, a_start, a_abort;
  logic [0:0]  a_halt, a_pass_i, a_core_rst_n, a_halted, a_pass, a_fail;
  logic        a_busy, a_done, a_timeout, a_aborted;
  logic [31:0] a_cycle_count;
  logic [1:0]  a_state_dbg;

  // three cores, staggered release, manual start
  logic        b_rst, b_start, b_abort;
  logic [2:0]  b_halt, b_pass_i, b_core_rst_n, b_halted, b_pass, b_fail;
  logic        b_busy, b_done, b_timeout, b_aborted;
  logic [31:0] b_cycle_count;
  logic [1:0]  b_state_dbg;

  single_cycle_run_ctrl dut_a (
    .clk(clk), .rst(a_rst), .start_i(a_start), .abort_i(a_abort),
    .halt_i(a_halt), .pass_i(a_pass_i), .core_rst_n(a_core_rst_n),
    .busy(a_busy), .done(a_done), .timeout(a_timeout), .aborted(a_aborted),
    .halted(a_halted), .pass(a_pass), .fail(a_fail),
    .cycle_count(a_cycle_count), .state_dbg(a_state_dbg)
  );

  single_cycle_run_ctrl #(
    .NUM_CORES(3), .RST_HOLD(2), .STAGGER(2), .MAX_CYCLES(20), .AUTO_START(0)
  ) dut_b (
    .clk(clk), .rst(b_rst), .start_i(b_start), .abort_i(b_abort),
    .halt_i(b_halt), .pass_i(b_pass_i), .core_rst_n(b_core_rst_n),
    .busy(b_busy), .done(b_done), .timeout(b_timeout), .aborted(b_aborted),
    .halted(b_halted), .pass(b_pass), .fail(b_fail),
    .cycle_count(b_cycle_count), .state_dbg(b_state_dbg)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // result word: {timeout, aborted, pass[2:0], fail[2:0], halted[2:0], cycle_count[7:0]}
  task automatic cmp(input string tag, input logic [18:0] obs);
    logic [18:0] e;
    if (exp_q.size() == 0) begin
      chk({tag, "_queue_empty"}, 32'd0, 32'd1);
    end else begin
      e = exp_q.pop_front();
      chk(tag, {13'd0, obs}, {13'd0, e});
    end
  endtask

  function automatic logic [18:0] pk_a();
    return {a_timeout, a_aborted, 2'b00, a_pass, 2'b00, a_fail, 2'b00, a_halted, a_cycle_count[7:0]};
  endfunction

  function automatic logic [18:0] pk_b();
    return {b_timeout, b_aborted, b_pass, b_fail, b_halted, b_cycle_count[7:0]};
  endfunction

  task automatic wait_done_a(input int budget, output int n);
    n = 0;
    while (!a_done && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("a_done_reached", {31'd0, a_done}, 32'd1);
  endtask

  task automatic wait_done_b(input int budget, output int n);
    n = 0;
    while (!b_done && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("b_done_reached", {31'd0, b_done}, 32'd1);
  endtask

  // From DONE: pulse start, walk two HOLD cycles; returns at the negedge of RUN cycle 1.
  task automatic start_a();
    a_start = 1'b1;
    @(negedge clk);
    a_start = 1'b0;
    chk("a_start_busy", {31'd0, a_busy}, 32'd1);
    chk("a_start_cleared", {13'd0, pk_a()}, 32'd0);
    @(negedge clk);
    chk("a_hold_rst", {31'd0, a_core_rst_n}, 32'd0);
    @(negedge clk);
    chk("a_run_release", {31'd0, a_core_rst_n}, 32'd1);
    chk("a_run_cnt0", a_cycle_count, 32'd0);
  endtask

  initial begin
    int n;
    a_rst = 1'b0; a_start = 1'b0; a_abort = 1'b0; a_halt = '0; a_pass_i = '0;
    b_rst = 1'b0; b_start = 1'b0; b_abort = 1'b0; b_halt = '0; b_pass_i = '0;
    repeat (2) @(negedge clk);

    // reset state
    chk("rst_core_rst_n", {31'd0, a_core_rst_n}, 32'd0);
    chk("rst_busy_done", {30'd0, a_busy, a_done}, 32'd0);
    chk("rst_status", {13'd0, pk_a()}, 32'd0);
    chk("rst_state", {30'd0, a_state_dbg}, 32'd0);
    chk("rst_b_core", {29'd0, b_core_rst_n}, 32'd0);

    // default run to timeout, timing from reset release
    a_rst = 1'b1; b_rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("a_idle_after_sync", {30'd0, a_state_dbg}, 32'd0);
    chk("a_idle_not_busy", {31'd0, a_busy}, 32'd0);
    @(negedge clk);
    chk("a_auto_hold", {31'd0, a_busy}, 32'd1);
    chk("a_hold0_rst", {31'd0, a_core_rst_n}, 32'd0);
    @(negedge clk);
    chk("a_hold1_rst", {31'd0, a_core_rst_n}, 32'd0);
    @(negedge clk);
    chk("a_release", {31'd0, a_core_rst_n}, 32'd1);
    chk("a_state_run", {30'd0, a_state_dbg}, 32'd2);
    exp_q.push_back({1'b1, 1'b0, 3'd0, 3'd1, 3'd0, 8'd5});
    wait_done_a(20, n);
    chk("a_run_len", n, 32'd5);
    cmp("a_timeout_run", pk_a());
    chk("a_done_core_rst", {31'd0, a_core_rst_n}, 32'd0);
    chk("a_done_not_busy", {31'd0, a_busy}, 32'd0);
    chk("b_no_auto_start", {30'd0, b_state_dbg}, 32'd0);

    // abort and no auto-restart while DONE
    a_abort = 1'b1;
    @(negedge clk);
    a_abort = 1'b0;
    chk("a_done_abort_ignored", {30'd0, a_done, a_aborted}, 32'd2);

    // pass halt in RUN cycle 3, start ignored in RUN
    start_a();
    a_start = 1'b1;
    @(negedge clk);
    a_start = 1'b0;
    @(negedge clk);
    a_halt = 1'b1; a_pass_i = 1'b1;
    exp_q.push_back({1'b0, 1'b0, 3'd1, 3'd0, 3'd1, 8'd3});
    @(negedge clk);
    a_halt = 1'b0; a_pass_i = 1'b0;
    wait_done_a(3, n);
    cmp("a_pass_c3", pk_a());

    // failing halt coinciding with budget exhaustion
    start_a();
    repeat (4) @(negedge clk);
    a_halt = 1'b1; a_pass_i = 1'b0;
    exp_q.push_back({1'b0, 1'b0, 3'd0, 3'd1, 3'd1, 8'd5});
    @(negedge clk);
    a_halt = 1'b0;
    wait_done_a(3, n);
    cmp("a_halt_at_budget", pk_a());

    // abort with simultaneous passing halt in RUN cycle 2
    start_a();
    @(negedge clk);
    a_abort = 1'b1; a_halt = 1'b1; a_pass_i = 1'b1;
    exp_q.push_back({1'b0, 1'b1, 3'd1, 3'd0, 3'd1, 8'd2});
    @(negedge clk);
    a_abort = 1'b0; a_halt = 1'b0; a_pass_i = 1'b0;
    chk("a_abort_next_edge", {31'd0, a_done}, 32'd1);
    cmp("a_abort_run", pk_a());
    a_start = 1'b1;
    @(negedge clk);
    a_start = 1'b0;
    chk("a_restart_cleared", {13'd0, pk_a()}, 32'd0);
    chk("a_restart_busy", {31'd0, a_busy}, 32'd1);

    // async reset in RUN cycle 2, then restart from IDLE
    repeat (3) @(negedge clk);
    chk("a_pre_rst_running", {31'd0, a_core_rst_n}, 32'd1);
    a_rst = 1'b0;
    #1;
    chk("a_async_core_rst", {31'd0, a_core_rst_n}, 32'd0);
    chk("a_async_status", {13'd0, pk_a()}, 32'd0);
    chk("a_async_busy", {31'd0, a_busy}, 32'd0);
    @(negedge clk);
    a_rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("a_rerun_idle", {30'd0, a_state_dbg}, 32'd0);
    @(negedge clk);
    chk("a_rerun_hold", {31'd0, a_busy}, 32'd1);
    a_halt = 1'b1; a_pass_i = 1'b1;
    @(negedge clk);
    a_halt = 1'b0; a_pass_i = 1'b0;
    @(negedge clk);
    chk("a_rerun_release", {31'd0, a_core_rst_n}, 32'd1);
    chk("a_halt_in_reset_ignored", {31'd0, a_halted}, 32'd0);
    exp_q.push_back({1'b1, 1'b0, 3'd0, 3'd1, 3'd0, 8'd5});
    wait_done_a(20, n);
    cmp("a_rerun_timeout", pk_a());

    // three cores: staggered releases, halt in HOLD, done after last halt
    b_start = 1'b1;
    @(negedge clk);
    b_start = 1'b0;
    chk("b_hold_busy", {31'd0, b_busy}, 32'd1);
    chk("b_hold_e1", {29'd0, b_core_rst_n}, 32'd0);
    @(negedge clk);
    chk("b_hold_e2", {29'd0, b_core_rst_n}, 32'd0);
    @(negedge clk);
    chk("b_rel_core0", {29'd0, b_core_rst_n}, 32'd1);
    b_halt = 3'b001; b_pass_i = 3'b001;
    @(negedge clk);
    b_halt = 3'b000; b_pass_i = 3'b000;
    chk("b_hold_halt_latched", {29'd0, b_halted}, 32'd1);
    chk("b_hold_e4", {29'd0, b_core_rst_n}, 32'd1);
    @(negedge clk);
    chk("b_rel_core1", {29'd0, b_core_rst_n}, 32'd3);
    @(negedge clk);
    chk("b_hold_e6", {29'd0, b_core_rst_n}, 32'd3);
    @(negedge clk);
    chk("b_rel_core2", {29'd0, b_core_rst_n}, 32'd7);
    chk("b_state_run", {30'd0, b_state_dbg}, 32'd2);
    b_halt = 3'b010; b_pass_i = 3'b000;
    @(negedge clk);
    chk("b_not_done_yet", {31'd0, b_done}, 32'd0);
    chk("b_halted_two", {29'd0, b_halted}, 32'd3);
    b_halt = 3'b100; b_pass_i = 3'b100;
    exp_q.push_back({1'b0, 1'b0, 3'b101, 3'b010, 3'b111, 8'd2});
    @(negedge clk);
    b_halt = 3'b000; b_pass_i = 3'b000;
    wait_done_b(3, n);
    cmp("b_all_halted", pk_b());
    chk("b_done_core_rst", {29'd0, b_core_rst_n}, 32'd0);
    chk("queue_drained", exp_q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
